// File: rtl/nor_pipe_pkg.sv
// Shared sizing helpers for the pipelined N-input NOR macro.
// Each stage word is {d[WIDTH-1:0], v}: the valid bit sits at position 0.
package nor_pipe_pkg;

    function automatic int STAGE_W(input int width);
        return width + 1;
    endfunction

    function automatic int SCAN_LEN(input int width, input int depth);
        return depth * STAGE_W(width);
    endfunction

    function automatic int BUS_LSB(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/nor_pipe_stage.sv
// One pipeline stage {d, v} with functional load and scan shift.
// Scan order inside a stage is scan_in -> v -> d[0] -> ... -> d[WIDTH-1] -> scan_out.
module nor_pipe_stage
    import nor_pipe_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             se,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    input  logic             scan_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out,
    output logic             scan_out
);

    localparam int SW = STAGE_W(WIDTH);

    logic [SW-1:0] stage_q;
    logic [SW-1:0] stage_d;

    // Scan shift wins over functional load; with neither, the stage holds.
    always_comb begin
        stage_d = stage_q;
        if (se) begin
            stage_d = {stage_q[SW-2:0], scan_in};
        end else if (en) begin
            stage_d = {d_in, v_in};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign v_out    = stage_q[0];
    assign d_out    = stage_q[SW-1:1];
    assign scan_out = stage_q[SW-1];

endmodule

// File: rtl/nor_pipe.sv
// Per-bit NOR across NIN input buses, registered through a DEPTH-stage
// pipeline with clock enable, valid tracking and a single scan chain.
module nor_pipe
    import nor_pipe_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NIN   = 2,
    parameter int DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NIN*WIDTH-1:0] i,
    input  logic                 vld_in,
    input  logic                 en,
    input  logic                 se,
    input  logic                 si,
    output logic [WIDTH-1:0]     nq,
    output logic                 vld_out,
    output logic                 so
);

    logic [WIDTH-1:0] any_one;
    logic [WIDTH-1:0] nor_r;

    always_comb begin
        any_one = '0;
        for (int k = 0; k < NIN; k++) begin
            any_one = any_one | i[BUS_LSB(k, WIDTH) +: WIDTH];
        end
        nor_r = ~any_one;
    end

    // Element 0 of each chain is the pipeline input; element DEPTH is the output.
    logic [WIDTH-1:0] d_chain [DEPTH+1];
    logic [DEPTH:0]   v_chain;
    logic [DEPTH:0]   scan_chain;

    assign d_chain[0]    = nor_r;
    assign v_chain[0]    = vld_in;
    assign scan_chain[0] = si;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            nor_pipe_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk      (clk),
                .nrst     (nrst),
                .en       (en),
                .se       (se),
                .d_in     (d_chain[gi]),
                .v_in     (v_chain[gi]),
                .scan_in  (scan_chain[gi]),
                .d_out    (d_chain[gi+1]),
                .v_out    (v_chain[gi+1]),
                .scan_out (scan_chain[gi+1])
            );
        end
    endgenerate

    assign nq      = d_chain[DEPTH];
    assign vld_out = v_chain[DEPTH];
    assign so      = scan_chain[DEPTH];

endmodule

// File: tb/tb_nor_pipe.sv
// Scoreboard bench for nor_pipe: three configurations share clk and nrst,
// expected outputs are queued at drive time and popped when they emerge.
module tb_nor_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;

    // Config A: WIDTH=1, NIN=2, DEPTH=1
    logic [1:0]  i_a;
    logic        vld_a, en_a, se_a, si_a;
    logic [0:0]  nq_a;
    logic        vo_a, so_a;
    // Config B: WIDTH=4, NIN=3, DEPTH=3
    logic [11:0] i_b;
    logic        vld_b, en_b, se_b, si_b;
    logic [3:0]  nq_b;
    logic        vo_b, so_b;
    // Config C: WIDTH=4, NIN=2, DEPTH=2 (scan length 10)
    logic [7:0]  i_c;
    logic        vld_c, en_c, se_c, si_c;
    logic [3:0]  nq_c;
    logic        vo_c, so_c;

    nor_pipe #(.WIDTH(1), .NIN(2), .DEPTH(1)) u_a (
        .clk(clk), .nrst(nrst), .i(i_a), .vld_in(vld_a), .en(en_a), .se(se_a),
        .si(si_a), .nq(nq_a), .vld_out(vo_a), .so(so_a)
    );
    nor_pipe #(.WIDTH(4), .NIN(3), .DEPTH(3)) u_b (
        .clk(clk), .nrst(nrst), .i(i_b), .vld_in(vld_b), .en(en_b), .se(se_b),
        .si(si_b), .nq(nq_b), .vld_out(vo_b), .so(so_b)
    );
    nor_pipe #(.WIDTH(4), .NIN(2), .DEPTH(2)) u_c (
        .clk(clk), .nrst(nrst), .i(i_c), .vld_in(vld_c), .en(en_c), .se(se_c),
        .si(si_c), .nq(nq_c), .vld_out(vo_c), .so(so_c)
    );

    localparam int L_C = 10;

    int n_cmp = 0;
    int n_mis = 0;

    logic [1:0] q_a [$];
    logic [4:0] q_b [$];
    logic [4:0] q_c [$];
    logic       q_s [$];
    logic [4:0] held_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nor_b(input logic [11:0] x);
        return ~(x[3:0] | x[7:4] | x[11:8]);
    endfunction

    function automatic logic [3:0] nor_c(input logic [7:0] x);
        return ~(x[3:0] | x[7:4]);
    endfunction

    task automatic step_a(input logic [1:0] iv, input logic v);
        logic [1:0] e;
        i_a = iv; vld_a = v; en_a = 1'b1;
        q_a.push_back({v, ~(iv[0] | iv[1])});
        @(posedge clk); #1;
        e = q_a.pop_front();
        check("a_nq", 32'(nq_a), 32'(e[0]));
        check("a_vld", 32'(vo_a), 32'(e[1]));
        check("a_so", 32'(so_a), 32'(e[0]));
        $display("a: i=%b vld_in=%b -> nq=%b vld_out=%b", iv, v, nq_a, vo_a);
    endtask

    task automatic step_b(input logic [11:0] iv, input logic v, input logic e_en);
        i_b = iv; vld_b = v; en_b = e_en;
        if (e_en) q_b.push_back({v, nor_b(iv)});
        @(posedge clk); #1;
        if (e_en) held_b = q_b.pop_front();
        check("b_nq", 32'(nq_b), 32'(held_b[3:0]));
        check("b_vld", 32'(vo_b), 32'(held_b[4]));
        check("b_so", 32'(so_b), 32'(held_b[3]));
        $display("b: i=%h vld_in=%b en=%b -> nq=%h vld_out=%b", iv, v, e_en, nq_b, vo_b);
    endtask

    task automatic step_c(input logic [7:0] iv, input logic v);
        logic [4:0] e;
        i_c = iv; vld_c = v; en_c = 1'b1; se_c = 1'b0;
        q_c.push_back({v, nor_c(iv)});
        @(posedge clk); #1;
        e = q_c.pop_front();
        check("c_nq", 32'(nq_c), 32'(e[3:0]));
        check("c_vld", 32'(vo_c), 32'(e[4]));
        $display("c: i=%h vld_in=%b -> nq=%h vld_out=%b", iv, v, nq_c, vo_c);
    endtask

    task automatic shift_c(input logic b);
        se_c = 1'b1; en_c = 1'b0; si_c = b;
        q_s.push_back(b);
        @(posedge clk); #1;
        check("c_so", 32'(so_c), 32'(q_s.pop_front()));
        $display("c scan: si=%b -> so=%b", b, so_c);
    endtask

    task automatic prefill_scan();
        q_s.delete();
        for (int k = 0; k < L_C - 1; k++) q_s.push_back(1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {30'd0, vo_a, nq_a}, 32'd0);
        check({tag, "_b"}, {26'd0, so_b, vo_b, nq_b}, 32'd0);
        check({tag, "_c"}, {26'd0, so_c, vo_c, nq_c}, 32'd0);
    endtask

    initial begin
        logic [9:0]  pat;
        logic [3:0]  exp_nq;
        logic [31:0] rnd;

        nrst = 1'b0;
        i_a = '1; i_b = '1; i_c = '1;
        vld_a = 1'b1; vld_b = 1'b1; vld_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        se_a = 1'b0; se_b = 1'b0; se_c = 1'b0;
        si_a = 1'b0; si_b = 1'b0; si_c = 1'b0;

        #2;
        check_zero("rst_pre_edge");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        nrst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        held_b = '0;
        repeat (2) q_b.push_back(5'd0);
        q_c.push_back(5'd0);

        // Truth table of the 2-input NOR cell
        step_a(2'b00, 1'b1);
        step_a(2'b01, 1'b1);
        step_a(2'b10, 1'b1);
        step_a(2'b11, 1'b1);
        step_a(2'b00, 1'b0);
        en_a = 1'b0;

        // Latency with a two-cycle enable freeze between beats
        step_b(12'h000, 1'b1, 1'b1);
        step_b(12'hfff, 1'b0, 1'b0);
        step_b(12'hfff, 1'b0, 1'b0);
        step_b(12'h124, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rnd = $urandom;
            step_b(rnd[11:0], rnd[12], (k < 3) ? 1'b1 : rnd[13]);
        end
        en_b = 1'b0;

        // Valid tracking: pattern 1,0,1 with data still flowing on the 0 beat
        step_c(8'h00, 1'b1);
        step_c(8'h35, 1'b0);
        step_c(8'h12, 1'b1);
        for (int k = 0; k < 3; k++) begin
            rnd = $urandom;
            step_c(rnd[7:0], rnd[8]);
        end

        @(negedge clk);
        nrst = 1'b0;
        #1;
        check_zero("rst_between");
        @(negedge clk);
        nrst = 1'b1;
        prefill_scan();

        // Scan load LSB-first, then parallel view of the final stage
        pat = 10'b1011001110;
        for (int k = 0; k < L_C; k++) shift_c(pat[k]);
        for (int b = 0; b < 4; b++) exp_nq[b] = pat[L_C - 1 - (6 + b)];
        check("c_scan_nq", 32'(nq_c), 32'(exp_nq));
        check("c_scan_vld", 32'(vo_c), 32'(pat[L_C - 1 - 5]));
        for (int k = 0; k < L_C; k++) shift_c(1'b0);

        // Asynchronous reset in the middle of a shift sequence
        for (int k = 0; k < 5; k++) shift_c(1'b1);
        #2;
        nrst = 1'b0;
        #1;
        check_zero("rst_mid_scan");
        @(negedge clk);
        nrst = 1'b1;
        prefill_scan();
        for (int k = 0; k < L_C; k++) shift_c(1'b1);
        se_c = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
